axi_dram_responder: RTL and testbench

AXI_DRAM_RESPONDER -- requirements
Module: axi_dram_responder

---
 rtl/axi_dram_responder_pkg.sv | 45 ++++
 rtl/axi_dram_responder_dram_bank.sv | 39 +++
 rtl/axi_dram_responder.sv | 175 +++++++++++++++++
 tb/tb_axi_dram_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dram_responder_pkg.sv
// Shared types and constants for the AXI DRAM responder.
package axi_dram_responder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    R_ADDR,
    R_WAIT,
    R_DATA,
    W_ADDR,
    W_DATA,
    W_RESP
  } state_e;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned LAT_W  = 4;
  localparam int unsigned ERR_W  = 8;

  localparam logic [ADDR_W-1:0] DRAM_BASE  = 17'h10000;
  localparam int unsigned       DRAM_DEPTH = 256;

  // Bit positions of the four 12-bit fields packed into a 64-bit entry
  localparam int unsigned FLD_A_HI = 63;
  localparam int unsigned FLD_A_LO = 52;
  localparam int unsigned FLD_B_HI = 51;
  localparam int unsigned FLD_B_LO = 40;
  localparam int unsigned FLD_C_HI = 31;
  localparam int unsigned FLD_C_LO = 20;
  localparam int unsigned FLD_D_HI = 19;
  localparam int unsigned FLD_D_LO = 8;

  // Build an entry from its four fields; unused bits are zero.
  function automatic logic [DATA_W-1:0] pack_fields(input logic [11:0] a, input logic [11:0] b,
                                                    input logic [11:0] c, input logic [11:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    r[FLD_A_HI:FLD_A_LO] = a;
    r[FLD_B_HI:FLD_B_LO] = b;
    r[FLD_C_HI:FLD_C_LO] = c;
    r[FLD_D_HI:FLD_D_LO] = d;
    return r;
  endfunction

endpackage

// File: rtl/axi_dram_responder_dram_bank.sv
// DRAM storage plus byte-address legality check and entry-index decode.
module dram_bank #(
  parameter logic [16:0] BASE  = axi_dram_responder_pkg::DRAM_BASE,
  parameter int unsigned DEPTH = axi_dram_responder_pkg::DRAM_DEPTH
) (
  input  logic        clk,
  input  logic [16:0] addr_i,
  output logic        legal_o,
  output logic [63:0] rd_data_o,
  input  logic        wr_en_i,
  input  logic [63:0] wr_data_i,
  input  logic        init_we_i,
  input  logic [7:0]  init_idx_i,
  input  logic [63:0] init_data_i
);
  import axi_dram_responder_pkg::*;

  localparam int unsigned FIRST = 32'(BASE);
  localparam int unsigned LAST  = FIRST + 32'(8 * (DEPTH - 1));

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  idx;

  assign legal_o   = (32'(addr_i) >= FIRST) && (32'(addr_i) <= LAST) && (addr_i[2:0] == 3'b000);
  assign idx       = IDX_W'((32'(addr_i) - FIRST) >> 3);
  assign rd_data_o = legal_o ? mem_q[idx] : '0;

  // Transaction write beats the preload port; illegal writes are dropped.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      if (legal_o) begin
        mem_q[idx] <= wr_data_i;
      end
    end else if (init_we_i) begin
      mem_q[init_idx_i] <= init_data_i;
    end
  end

endmodule

// File: rtl/axi_dram_responder.sv
// Single-outstanding AXI-style read/write responder in front of a DRAM bank.
module axi_dram_responder #(
  parameter logic [16:0] BASE  = axi_dram_responder_pkg::DRAM_BASE,
  parameter int unsigned DEPTH = axi_dram_responder_pkg::DRAM_DEPTH,
  parameter int unsigned R_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  input  logic        B_READY,
  input  logic        init_we,
  input  logic [7:0]  init_idx,
  input  logic [63:0] init_data,
  output logic [7:0]  err_cnt
);
  import axi_dram_responder_pkg::*;

  // Data-phase states share names with the R_DATA/W_DATA ports
  localparam state_e           S_RDATA   = axi_dram_responder_pkg::R_DATA;
  localparam state_e           S_WDATA   = axi_dram_responder_pkg::W_DATA;
  localparam logic [LAT_W-1:0] LAST_WAIT = LAT_W'(R_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              ar_ready_q, ar_ready_d;
  logic              r_valid_q, r_valid_d;
  logic              aw_ready_q, aw_ready_d;
  logic              w_ready_q, w_ready_d;
  logic              b_valid_q, b_valid_d;

  logic [ADDR_W-1:0] bank_addr;
  logic              bank_legal;
  logic [DATA_W-1:0] bank_rdata;
  logic              mem_we;
  logic              err_inc;

  // The address being handshaked is looked up directly so R_LAT=1 still works
  assign bank_addr = (state_q == R_ADDR) ? AR_ADDR : addr_q;

  dram_bank #(
    .BASE  (BASE),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk         (clk),
    .addr_i      (bank_addr),
    .legal_o     (bank_legal),
    .rd_data_o   (bank_rdata),
    .wr_en_i     (mem_we && !rst),
    .wr_data_i   (W_DATA),
    .init_we_i   (init_we && (state_q == IDLE) && !rst),
    .init_idx_i  (init_idx),
    .init_data_i (init_data)
  );

  // State and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      r_data_q   <= '0;
      err_q      <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      r_data_q   <= r_data_d;
      err_q      <= err_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
    end
  end

  // Next-state, capture and error accounting; errors count only on completion
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    r_data_d  = r_data_q;
    w_ready_d = 1'b0;
    mem_we    = 1'b0;
    err_inc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (AR_VALID) begin
          state_d = R_ADDR;
        end else if (AW_VALID) begin
          state_d = W_ADDR;
        end
      end
      R_ADDR: begin
        addr_d  = AR_ADDR;
        cnt_d   = LAT_W'(1);
        state_d = (R_LAT <= 1) ? S_RDATA : R_WAIT;
      end
      R_WAIT: begin
        if (cnt_q >= LAST_WAIT) begin
          state_d = S_RDATA;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      S_RDATA: begin
        if (R_READY) begin
          state_d = IDLE;
          err_inc = !bank_legal;
        end
      end
      W_ADDR: begin
        addr_d  = AW_ADDR;
        state_d = S_WDATA;
      end
      S_WDATA: begin
        if (w_ready_q) begin
          if (W_VALID) begin
            mem_we  = 1'b1;
            state_d = W_RESP;
          end
        end else if (W_VALID) begin
          w_ready_d = 1'b1;
        end
      end
      W_RESP: begin
        if (B_READY) begin
          state_d = IDLE;
          err_inc = !bank_legal;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == S_RDATA) && (state_q != S_RDATA)) begin
      r_data_d = bank_rdata;
    end

    err_d      = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
    ar_ready_d = (state_d == R_ADDR);
    r_valid_d  = (state_d == S_RDATA);
    aw_ready_d = (state_d == W_ADDR);
    b_valid_d  = (state_d == W_RESP);
  end

  assign AR_READY = ar_ready_q;
  assign R_VALID  = r_valid_q;
  assign R_DATA   = r_data_q;
  assign AW_READY = aw_ready_q;
  assign W_READY  = w_ready_q;
  assign B_VALID  = b_valid_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_axi_dram_responder.sv
// Self-checking bench for axi_dram_responder: vector table plus corner sequences.
module tb_axi_dram_responder;

  localparam int unsigned R_LAT = 2;

  logic        clk;
  logic        rst;
  logic        AR_VALID;
  logic [16:0] AR_ADDR;
  logic        AR_READY;
  logic        R_VALID;
  logic [63:0] R_DATA;
  logic        R_READY;
  logic        AW_VALID;
  logic [16:0] AW_ADDR;
  logic        AW_READY;
  logic        W_VALID;
  logic [63:0] W_DATA;
  logic        W_READY;
  logic        B_VALID;
  logic        B_READY;
  logic        init_we;
  logic [7:0]  init_idx;
  logic [63:0] init_data;
  logic [7:0]  err_cnt;

  axi_dram_responder #(.R_LAT(R_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .AR_VALID  (AR_VALID),
    .AR_ADDR   (AR_ADDR),
    .AR_READY  (AR_READY),
    .R_VALID   (R_VALID),
    .R_DATA    (R_DATA),
    .R_READY   (R_READY),
    .AW_VALID  (AW_VALID),
    .AW_ADDR   (AW_ADDR),
    .AW_READY  (AW_READY),
    .W_VALID   (W_VALID),
    .W_DATA    (W_DATA),
    .W_READY   (W_READY),
    .B_VALID   (B_VALID),
    .B_READY   (B_READY),
    .init_we   (init_we),
    .init_idx  (init_idx),
    .init_data (init_data),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] rq[$];
  int          bq[$];
  bit          aw_seen;

  typedef struct {
    bit          wr;
    logic [16:0] addr;
    logic [63:0] data;
    logic [7:0]  err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard: compare each completed R/B handshake against queued expectations
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (AW_READY) aw_seen = 1'b1;
      if (R_VALID && R_READY) begin
        chk("r_sb_pending", 64'(rq.size() != 0), 64'd1);
        if (rq.size() != 0) chk("r_data", R_DATA, rq.pop_front());
      end
      if (B_VALID && B_READY) begin
        chk("b_sb_pending", 64'(bq.size() != 0), 64'd1);
        if (bq.size() != 0) void'(bq.pop_front());
      end
    end
  end

  task automatic init_write(input logic [7:0] idx, input logic [63:0] d);
    init_we = 1'b1; init_idx = idx; init_data = d;
    tick();
    init_we = 1'b0;
  endtask

  task automatic do_read(input logic [16:0] a, input logic [63:0] exp, input int hold);
    bit ok;
    int lat;
    logic [63:0] d0;
    rq.push_back(exp);
    AR_ADDR = a; AR_VALID = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (AR_READY) begin ok = 1'b1; break; end
    end
    chk("ar_ready_seen", 64'(ok), 64'd1);
    lat = -1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 1) AR_VALID = 1'b0;
      if (R_VALID) begin lat = t; break; end
    end
    AR_VALID = 1'b0;
    chk("r_latency", 64'(lat), 64'(R_LAT));
    d0 = R_DATA;
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("r_hold_valid", 64'(R_VALID), 64'd1);
      chk("r_hold_data", R_DATA, d0);
    end
    R_READY = 1'b1;
    tick();
    R_READY = 1'b0;
    chk("r_valid_drop", 64'(R_VALID), 64'd0);
  endtask

  task automatic do_write(input logic [16:0] a, input logic [63:0] d);
    bit ok;
    bq.push_back(1);
    AW_ADDR = a; AW_VALID = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (AW_READY) begin ok = 1'b1; break; end
    end
    chk("aw_ready_seen", 64'(ok), 64'd1);
    W_DATA = d; W_VALID = 1'b1;
    ok = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t == 1) AW_VALID = 1'b0;
      if (W_READY) begin ok = 1'b1; break; end
    end
    AW_VALID = 1'b0;
    chk("w_ready_seen", 64'(ok), 64'd1);
    chk("b_not_early", 64'(B_VALID), 64'd0);
    tick();
    W_VALID = 1'b0;
    chk("b_after_w", 64'(B_VALID), 64'd1);
    B_READY = 1'b1;
    tick();
    B_READY = 1'b0;
    chk("b_valid_drop", 64'(B_VALID), 64'd0);
  endtask

  initial begin
    vec_t        tbl[10];
    bit          ok;
    logic [63:0] p0;
    logic [63:0] p5;
    logic [63:0] wv;

    p5 = 64'h0123_4567_89AB_CDEF;
    wv = 64'hFFF0_0100_0000_0000;
    p0 = axi_dram_responder_pkg::pack_fields(12'hABC, 12'h123, 12'h456, 12'h789);

    tbl[0] = '{1'b0, 17'h10028, p5,                    8'd0};
    tbl[1] = '{1'b1, 17'h107F8, wv,                    8'd0};
    tbl[2] = '{1'b0, 17'h107F8, wv,                    8'd0};
    tbl[3] = '{1'b0, 17'h0FFF8, 64'd0,                 8'd1};
    tbl[4] = '{1'b1, 17'h10004, 64'hDEAD_BEEF_DEAD_BEEF, 8'd2};
    tbl[5] = '{1'b0, 17'h10000, p0,                    8'd2};
    tbl[6] = '{1'b0, 17'h10800, 64'd0,                 8'd3};
    tbl[7] = '{1'b0, 17'h107FC, 64'd0,                 8'd4};
    tbl[8] = '{1'b1, 17'h10000, 64'h5555_AAAA_0000_1111, 8'd4};
    tbl[9] = '{1'b0, 17'h10000, 64'h5555_AAAA_0000_1111, 8'd4};

    rst = 1'b1; AR_VALID = 1'b0; AR_ADDR = '0; R_READY = 1'b0;
    AW_VALID = 1'b0; AW_ADDR = '0; W_VALID = 1'b0; W_DATA = '0; B_READY = 1'b0;
    init_we = 1'b0; init_idx = '0; init_data = '0; aw_seen = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_hs", 64'({AR_READY, R_VALID, AW_READY, W_READY, B_VALID}), 64'd0);
    chk("reset_rdata", R_DATA, 64'd0);
    chk("reset_err", 64'(err_cnt), 64'd0);

    init_write(8'd5, p5);
    init_write(8'd0, p0);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) do_write(tbl[i].addr, tbl[i].data);
      else           do_read(tbl[i].addr, tbl[i].data, 0);
      chk("tbl_err_cnt", 64'(err_cnt), 64'(tbl[i].err));
    end

    // Master stalls R_READY for five cycles
    do_read(17'h10028, p5, 5);

    // Simultaneous AR and AW: read completes before AW is accepted
    aw_seen  = 1'b0;
    AW_ADDR  = 17'h10010;
    AW_VALID = 1'b1;
    do_read(17'h10028, p5, 0);
    chk("aw_held_off", 64'(aw_seen), 64'd0);
    do_write(17'h10010, 64'h2222_3333_4444_5555);
    do_read(17'h10010, 64'h2222_3333_4444_5555, 0);

    // Reset taken in R_WAIT abandons the read; memory survives
    AR_ADDR = 17'h10028; AR_VALID = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (AR_READY) begin ok = 1'b1; break; end
    end
    chk("rst_ar_seen", 64'(ok), 64'd1);
    tick();
    AR_VALID = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_hs", 64'({AR_READY, R_VALID, AW_READY, W_READY, B_VALID}), 64'd0);
    chk("rst_mid_rdata", R_DATA, 64'd0);
    chk("rst_mid_err", 64'(err_cnt), 64'd0);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("rst_no_resp", 64'(R_VALID), 64'd0);
    end
    do_read(17'h10028, p5, 0);
    chk("post_rst_err", 64'(err_cnt), 64'd0);

    tick();
    chk("rq_drained", 64'(rq.size()), 64'd0);
    chk("bq_drained", 64'(bq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
